// File: rtl/aduli_calib_sequencer.sv
// aduli_calib_sequencer
//
// Top-level calibration sequencer for the ADULI LED string. Walks every LED address bit
// through NUM_PHASES display patterns. For each (bit, phase) step it requests the pattern,
// waits for the display to report valid plus a settle delay, launches one calibration step
// and waits for it to finish. Each attempt has a cycle budget; on expiry the step is retried
// up to MAX_RETRIES times before a sticky error is raised.
//
// Optional feature: define ADULI_SEQ_SINGLE_STEP_EN to park in HOLD after every completed,
// non-final step until proceed_in is asserted. Without it proceed_in is ignored.
//
// Ports:
//   clk_in                      system clock
//   rst_n_in                    synchronous active-low reset
//   start_in                    start a sequence (level, ignored while busy)
//   abort_in                    abort the sequence, back to IDLE
//   proceed_in                  single-step advance out of HOLD
//   led_display_valid_in        pulse: requested pattern is displayed
//   calibration_step_ready_in   step FSM idle/ready
//   calibration_step_going_in   step FSM accepted the start
//   led_addr_bit_sel_out        current address bit
//   phase_out                   current pattern phase
//   led_addr_bit_sel_start_out  one-cycle pattern request
//   calibration_start_out       step start, held until going is seen
//   calibration_first_out       marks the very first step
//   busy_out                    sequence in progress
//   done_out                    one-cycle pulse on successful completion
//   error_out                   sticky timeout failure
//   retry_count_out             retries used on the current step
//   state_out                   state encoding (IDLE=0 .. ERROR=6)
module aduli_calib_sequencer #(
  parameter int unsigned NUM_LEDS               = 50,
  parameter int unsigned LED_ADDRESS_WIDTH      = $clog2(NUM_LEDS),
  parameter int unsigned LED_ADDR_BIT_SEL_WIDTH = $clog2(LED_ADDRESS_WIDTH),
  parameter int unsigned NUM_PHASES             = 2,
  parameter int unsigned SETTLE_CYCLES          = 1024,
  parameter int unsigned TIMEOUT_CYCLES         = 2**20,
  parameter int unsigned MAX_RETRIES            = 2,
  localparam int unsigned PhaseW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic                              abort_in,
  input  logic                              proceed_in,
  input  logic                              led_display_valid_in,
  input  logic                              calibration_step_ready_in,
  input  logic                              calibration_step_going_in,
  output logic [LED_ADDR_BIT_SEL_WIDTH-1:0] led_addr_bit_sel_out,
  output logic [PhaseW-1:0]                 phase_out,
  output logic                              led_addr_bit_sel_start_out,
  output logic                              calibration_start_out,
  output logic                              calibration_first_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              error_out,
  output logic [RetryW-1:0]                 retry_count_out,
  output logic [2:0]                        state_out
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned ToW     = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned BitExtW = LED_ADDR_BIT_SEL_WIDTH + 1;
  localparam int unsigned PhExtW  = PhaseW + 1;

  localparam logic [SettleW-1:0] SettleLoad = SettleW'(SETTLE_CYCLES);
  localparam logic [ToW-1:0]     ToLast     = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [BitExtW-1:0] BitLimit   = BitExtW'(LED_ADDRESS_WIDTH);
  localparam logic [PhExtW-1:0]  PhLimit    = PhExtW'(NUM_PHASES);
  localparam logic [RetryW-1:0]  RetryMax   = RetryW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StShow   = 3'd1,
    StSettle = 3'd2,
    StLaunch = 3'd3,
    StRun    = 3'd4,
    StHold   = 3'd5,
    StError  = 3'd6
  } state_e;

  state_e                      state_q;
  logic [LED_ADDR_BIT_SEL_WIDTH-1:0] bit_q;
  logic [PhaseW-1:0]           phase_q;
  logic [RetryW-1:0]           retry_q;
  logic                        sel_start_q;
  logic                        cal_start_q;
  logic                        first_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        error_q;
  logic [SettleW-1:0]          settle_cnt_q;
  logic [ToW-1:0]              to_cnt_q;
  logic                        valid_seen_q;
  logic                        going_seen_q;

  logic [BitExtW-1:0] bit_inc;
  logic [PhExtW-1:0]  ph_inc;
  logic               phase_wraps;
  logic               last_step;
  logic               valid_seen;
  logic               attempt_active;
  logic               step_done;
  logic               timeout;
  logic               first_step;

  // Increments are evaluated one bit wider so the limit compares cannot wrap.
  assign bit_inc        = {1'b0, bit_q} + BitExtW'(1);
  assign ph_inc         = {1'b0, phase_q} + PhExtW'(1);
  assign phase_wraps    = (ph_inc >= PhLimit);
  assign last_step      = phase_wraps && (bit_inc >= BitLimit);
  // A valid in the SHOW entry cycle counts, so the latch is ORed with the live input.
  assign valid_seen     = valid_seen_q | led_display_valid_in;
  assign attempt_active = (state_q == StShow) || (state_q == StSettle) ||
                          (state_q == StLaunch) || (state_q == StRun);
  // Ready before going has been seen belongs to the previous step and is ignored.
  assign step_done      = (state_q == StRun) && going_seen_q && calibration_step_ready_in;
  assign timeout        = attempt_active && (to_cnt_q == ToLast);
  assign first_step     = (bit_q == '0) && (phase_q == '0);

`ifndef ADULI_SEQ_SINGLE_STEP_EN
  logic unused_proceed;
  assign unused_proceed = proceed_in;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= StIdle;
      bit_q        <= '0;
      phase_q      <= '0;
      retry_q      <= '0;
      sel_start_q  <= 1'b0;
      cal_start_q  <= 1'b0;
      first_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      valid_seen_q <= 1'b0;
      going_seen_q <= 1'b0;
    end else begin
      sel_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (attempt_active && (to_cnt_q != ToLast)) begin
        to_cnt_q <= to_cnt_q + ToW'(1);
      end

      if (abort_in && (state_q != StIdle)) begin
        state_q      <= StIdle;
        bit_q        <= '0;
        phase_q      <= '0;
        retry_q      <= '0;
        cal_start_q  <= 1'b0;
        first_q      <= 1'b0;
        busy_q       <= 1'b0;
        error_q      <= 1'b0;
        settle_cnt_q <= '0;
        to_cnt_q     <= '0;
        valid_seen_q <= 1'b0;
        going_seen_q <= 1'b0;
      end else if (step_done) begin
        retry_q     <= '0;
        cal_start_q <= 1'b0;
        if (last_step) begin
          done_q  <= 1'b1;
          state_q <= StIdle;
          busy_q  <= 1'b0;
          bit_q   <= '0;
          phase_q <= '0;
          first_q <= 1'b0;
        end else begin
          if (phase_wraps) begin
            phase_q <= '0;
            bit_q   <= bit_inc[LED_ADDR_BIT_SEL_WIDTH-1:0];
          end else begin
            phase_q <= ph_inc[PhaseW-1:0];
          end
`ifdef ADULI_SEQ_SINGLE_STEP_EN
          state_q <= StHold;
`else
          sel_start_q  <= 1'b1;
          to_cnt_q     <= '0;
          valid_seen_q <= 1'b0;
          state_q      <= StShow;
`endif
        end
      end else if (timeout) begin
        cal_start_q <= 1'b0;
        first_q     <= first_step;
        if (retry_q < RetryMax) begin
          retry_q      <= retry_q + RetryW'(1);
          sel_start_q  <= 1'b1;
          to_cnt_q     <= '0;
          valid_seen_q <= 1'b0;
          state_q      <= StShow;
        end else begin
          state_q <= StError;
          error_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          StIdle, StError: begin
            if (start_in) begin
              bit_q        <= '0;
              phase_q      <= '0;
              retry_q      <= '0;
              first_q      <= 1'b1;
              error_q      <= 1'b0;
              cal_start_q  <= 1'b0;
              busy_q       <= 1'b1;
              sel_start_q  <= 1'b1;
              to_cnt_q     <= '0;
              valid_seen_q <= 1'b0;
              state_q      <= StShow;
            end
          end
          StShow: begin
            valid_seen_q <= valid_seen;
            if (valid_seen) begin
              if (SETTLE_CYCLES == 0) begin
                state_q <= StLaunch;
              end else begin
                settle_cnt_q <= SettleLoad;
                state_q      <= StSettle;
              end
            end
          end
          StSettle: begin
            // Leaves after SETTLE_CYCLES cycles here; counter ends at zero.
            if (settle_cnt_q != '0) begin
              settle_cnt_q <= settle_cnt_q - SettleW'(1);
            end
            if (settle_cnt_q <= SettleW'(1)) begin
              state_q <= StLaunch;
            end
          end
          StLaunch: begin
            if (calibration_step_ready_in) begin
              cal_start_q  <= 1'b1;
              going_seen_q <= 1'b0;
              state_q      <= StRun;
            end
          end
          StRun: begin
            if (calibration_step_going_in) begin
              cal_start_q  <= 1'b0;
              first_q      <= 1'b0;
              going_seen_q <= 1'b1;
            end
          end
          StHold: begin
`ifdef ADULI_SEQ_SINGLE_STEP_EN
            if (proceed_in) begin
              sel_start_q  <= 1'b1;
              to_cnt_q     <= '0;
              valid_seen_q <= 1'b0;
              state_q      <= StShow;
            end
`else
            state_q <= StIdle;
`endif
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign led_addr_bit_sel_out       = bit_q;
  assign phase_out                  = phase_q;
  assign led_addr_bit_sel_start_out = sel_start_q;
  assign calibration_start_out      = cal_start_q;
  assign calibration_first_out      = first_q;
  assign busy_out                   = busy_q;
  assign done_out                   = done_q;
  assign error_out                  = error_q;
  assign retry_count_out            = retry_q;
  assign state_out                  = state_q;

endmodule

// File: tb/tb_aduli_calib_sequencer.sv
module tb_aduli_calib_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: SETTLE_CYCLES=4, TIMEOUT_CYCLES=64, MAX_RETRIES=2
  logic       rst_n, start, abort_s, proceed, valid, ready, going;
  logic [2:0] bit_sel;
  logic [0:0] phase;
  logic       pulse, cal_start, first, busy, done, error;
  logic [1:0] retry;
  logic [2:0] state;

  // Zero-settle instance
  logic       z_start, z_abort, z_valid, z_ready, z_going;
  logic [2:0] z_bit_sel;
  logic [0:0] z_phase;
  logic       z_pulse, z_cal_start, z_first, z_busy, z_done, z_error;
  logic [1:0] z_retry;
  logic [2:0] z_state;

  aduli_calib_sequencer #(
    .NUM_LEDS(50), .NUM_PHASES(2), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64), .MAX_RETRIES(2)
  ) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .abort_in(abort_s),
    .proceed_in(proceed), .led_display_valid_in(valid),
    .calibration_step_ready_in(ready), .calibration_step_going_in(going),
    .led_addr_bit_sel_out(bit_sel), .phase_out(phase),
    .led_addr_bit_sel_start_out(pulse), .calibration_start_out(cal_start),
    .calibration_first_out(first), .busy_out(busy), .done_out(done), .error_out(error),
    .retry_count_out(retry), .state_out(state)
  );

  aduli_calib_sequencer #(
    .NUM_LEDS(50), .NUM_PHASES(2), .SETTLE_CYCLES(0), .TIMEOUT_CYCLES(64), .MAX_RETRIES(2)
  ) u_dut_z (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(z_start), .abort_in(z_abort),
    .proceed_in(1'b0), .led_display_valid_in(z_valid),
    .calibration_step_ready_in(z_ready), .calibration_step_going_in(z_going),
    .led_addr_bit_sel_out(z_bit_sel), .phase_out(z_phase),
    .led_addr_bit_sel_start_out(z_pulse), .calibration_start_out(z_cal_start),
    .calibration_first_out(z_first), .busy_out(z_busy), .done_out(z_done),
    .error_out(z_error), .retry_count_out(z_retry), .state_out(z_state)
  );

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int done_cnt  = 0;

  always @(posedge clk) begin
    if (pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int lim, output int n);
    n = 0;
    while (pulse !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("pattern_pulse_seen", {31'd0, pulse}, 32'd1);
  endtask

  task automatic wait_start(input int lim, output int n);
    n = 0;
    while (cal_start !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("cal_start_seen", {31'd0, cal_start}, 32'd1);
  endtask

  task automatic wait_error(input int lim, output int n);
    n = 0;
    while (error !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("error_seen", {31'd0, error}, 32'd1);
  endtask

  // One step with the standard responder: valid 3 cycles after the pulse, going one cycle
  // after start, ready ten cycles after start. Ends on the cycle after completion.
  task automatic run_step(input int eb, input int ep, input bit ef, input bit do_abort);
    int n;
    string s;
    s = $sformatf("step_%0d_%0d", eb, ep);
    wait_pulse(40, n);
    chk({s, "_bit"}, bit_sel, eb);
    chk({s, "_phase"}, phase, ep);
    chk({s, "_retry"}, retry, 0);
    tick();
    tick();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_start(20, n);
    chk({s, "_settle_latency"}, n, 5);
    chk({s, "_first"}, first, ef);
    chk({s, "_busy"}, busy, 1);
    ready = 1'b0;
    tick();
    going = 1'b1;
    tick();
    going = 1'b0;
    chk({s, "_start_drop"}, cal_start, 0);
    chk({s, "_first_drop"}, first, 0);
    repeat (8) tick();
    ready = 1'b1;
    if (do_abort) abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
  endtask

  initial begin
    int n;
    int pbase;
    int dbase;
    rst_n = 1'b0;
    start = 1'b0;
    abort_s = 1'b0;
    valid = 1'b0;
    ready = 1'b1;
    going = 1'b0;
`ifdef ADULI_SEQ_SINGLE_STEP_EN
    proceed = 1'b1;
`else
    proceed = 1'b0;
`endif
    z_start = 1'b0;
    z_abort = 1'b0;
    z_valid = 1'b0;
    z_ready = 1'b1;
    z_going = 1'b0;

    // Reset
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_outputs", {bit_sel, phase, pulse, cal_start, first, busy, done, error, retry}, 0);
    chk("rst_z_outputs", {z_state, z_bit_sel, z_phase, z_pulse, z_cal_start, z_first,
                          z_busy, z_done, z_error, z_retry}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_rst", state, 0);

    // Zero settle, valid in SHOW entry cycle: start two cycles after the pulse
    z_start = 1'b1;
    tick();
    z_start = 1'b0;
    chk("z_pulse", z_pulse, 1);
    z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    chk("z_launch_state", z_state, 3);
    chk("z_start_not_yet", z_cal_start, 0);
    tick();
    chk("z_start_rise", z_cal_start, 1);
    chk("z_run_state", z_state, 4);
    z_abort = 1'b1;
    tick();
    z_abort = 1'b0;
    chk("z_abort_idle", z_state, 0);

    // Full sequence: 12 steps then one done pulse
    pbase = pulse_cnt;
    dbase = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) run_step(i / 2, i % 2, (i == 0), 1'b0);
    chk("seq_done_pulse", done, 1);
    chk("seq_busy_after", busy, 0);
    chk("seq_idle_after", state, 0);
    tick();
    chk("seq_done_one_cycle", done, 0);
    repeat (5) tick();
    chk("seq_pulse_count", pulse_cnt - pbase, 12);
    chk("seq_done_count", done_cnt - dbase, 1);

    // Ready held high through RUN before going arrives
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pulse(5, n);
    tick();
    tick();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    wait_start(20, n);
    chk("early_ready_first", first, 1);
    repeat (5) tick();
    chk("early_ready_still_run", state, 4);
    chk("early_ready_start_held", cal_start, 1);
    going = 1'b1;
    tick();
    going = 1'b0;
    chk("early_ready_start_drop", cal_start, 0);
    chk("early_ready_run_state", state, 4);
    tick();
    chk("early_ready_next_pulse", pulse, 1);
    chk("early_ready_next_phase", phase, 1);
    chk("early_ready_next_bit", bit_sel, 0);
    chk("early_ready_first_cleared", first, 0);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("early_ready_abort_busy", busy, 0);

    // Timeout with retries, display never valid
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_pulse(5, n);
    chk("to_retry0", retry, 0);
    tick();
    wait_pulse(80, n);
    chk("to_gap1", n, 63);
    chk("to_retry1", retry, 1);
    chk("to_bitphase1", {bit_sel, phase}, 0);
    tick();
    wait_pulse(80, n);
    chk("to_gap2", n, 63);
    chk("to_retry2", retry, 2);
    tick();
    wait_error(80, n);
    chk("to_err_gap", n, 63);
    chk("to_err_state", state, 6);
    chk("to_err_busy", busy, 0);
    chk("to_err_retry_held", retry, 2);
    chk("to_err_first", first, 1);
    repeat (5) tick();
    chk("to_err_sticky", error, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_error_clr", error, 0);
    chk("restart_pulse", pulse, 1);
    chk("restart_retry", retry, 0);
    chk("restart_bitphase", {bit_sel, phase}, 0);
    chk("restart_state", state, 1);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("restart_abort_idle", state, 0);

    // Abort in RUN at step (3,1), coincident with ready
    dbase = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) run_step(i / 2, i % 2, (i == 0), 1'b0);
    run_step(3, 1, 1'b0, 1'b1);
    chk("abort_state", state, 0);
    chk("abort_outputs", {bit_sel, phase, pulse, cal_start, first, busy, done, error, retry},
        0);
    repeat (10) tick();
    chk("abort_no_done", done_cnt - dbase, 0);

`ifdef ADULI_SEQ_SINGLE_STEP_EN
    // Single-step: park in HOLD until proceed
    proceed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_step(0, 0, 1'b1, 1'b0);
    chk("hold_entry", state, 5);
    pbase = pulse_cnt;
    repeat (100) tick();
    chk("hold_stays", state, 5);
    chk("hold_no_pulse", pulse_cnt - pbase, 0);
    proceed = 1'b1;
    tick();
    proceed = 1'b0;
    chk("hold_proceed_pulse", pulse, 1);
    chk("hold_proceed_bitphase", {bit_sel, phase}, 1);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("hold_abort_idle", state, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
